// File: rtl/song_sequencer.sv
// song_sequencer: walks a melody ROM with tempo-timed notes and silent gaps, keyboard input overrides the output.
// Define SONG_SEQ_LOOP_EN to replay the song from address 0 instead of ending at the end marker or address wrap.
module song_sequencer #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [7:0]        key_notes,
    input  logic [1:0]        key_shift,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        notes_out,
    output logic [1:0]        shift_out,
    output logic              playing,
    output logic              done,
    output logic              src
);
    localparam int PW = 5 + $clog2(BEAT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int CW = PW > GW ? PW : GW;
`ifdef SONG_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, PLAY, GAP, DONE} state_t;
    state_t            st, st_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [4:0]        dur, dur_n;
    logic [7:0]        lat_mask, lat_mask_n, seq_mask, seq_mask_n;
    logic [1:0]        lat_shift, lat_shift_n, seq_shift, seq_shift_n;
    logic [PW-1:0]     beats;
    logic              hold, seq_on;

    assign beats  = PW'(dur == 5'd0 ? 5'd1 : dur) * PW'(BEAT_CYCLES) - PW'(1);
    assign hold   = pause && st != DONE;
    assign seq_on = (st_n == PLAY || st_n == GAP) && !pause;

    always_comb begin
        st_n        = st;
        ptr_n       = ptr;
        cnt_n       = cnt;
        dur_n       = dur;
        lat_mask_n  = lat_mask;
        lat_shift_n = lat_shift;
        seq_mask_n  = seq_mask;
        seq_shift_n = seq_shift;
        if (stop || start) begin
            st_n       = stop ? IDLE : FETCH;
            ptr_n      = '0;
            cnt_n      = '0;
            seq_mask_n = '0;
        end else if (!hold) begin
            case (st)
                IDLE:  st_n = IDLE;
                FETCH: st_n = WAIT;
                WAIT: begin
                    if (rom_data[15]) begin
                        st_n  = LOOP ? FETCH : DONE;
                        ptr_n = '0;
                    end else begin
                        lat_shift_n = rom_data[14:13];
                        dur_n       = rom_data[12:8];
                        lat_mask_n  = rom_data[7:0];
                        st_n        = LOAD;
                    end
                end
                LOAD: begin
                    cnt_n       = CW'(beats);
                    seq_mask_n  = lat_mask;
                    seq_shift_n = lat_shift;
                    st_n        = PLAY;
                end
                PLAY: begin
                    cnt_n      = cnt == '0 ? CW'(GAP_CYCLES - 1) : cnt - CW'(1);
                    seq_mask_n = cnt == '0 ? 8'h00 : seq_mask;
                    st_n       = cnt == '0 ? GAP : PLAY;
                end
                GAP: begin
                    cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
                    ptr_n = cnt == '0 ? ptr + ADDR_W'(1) : ptr;
                    st_n  = cnt != '0 ? GAP : (&ptr && !LOOP) ? DONE : FETCH;
                end
                DONE:    st_n = IDLE;
                default: st_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            dur       <= '0;
            lat_mask  <= '0;
            lat_shift <= '0;
            seq_mask  <= '0;
            seq_shift <= '0;
            rom_addr  <= '0;
            notes_out <= '0;
            shift_out <= '0;
            playing   <= 1'b0;
            done      <= 1'b0;
            src       <= 1'b0;
        end else begin
            st        <= st_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            dur       <= dur_n;
            lat_mask  <= lat_mask_n;
            lat_shift <= lat_shift_n;
            seq_mask  <= seq_mask_n;
            seq_shift <= seq_shift_n;
            rom_addr  <= st_n == IDLE ? '0 : ptr_n;
            notes_out <= |key_notes ? key_notes : seq_on ? seq_mask_n : 8'h00;
            shift_out <= |key_notes ? key_shift : seq_on ? seq_shift_n : 2'b00;
            src       <= ~|key_notes && seq_on;
            playing   <= st_n != IDLE;
            done      <= st_n == DONE;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed and randomized playback checked cycle by cycle against a timeline model of the song.
module tb_song_sequencer;
    localparam int B = 4;
    localparam int G = 2;
`ifdef SONG_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  key_notes = 8'h00;
    logic [1:0]  key_shift = 2'b00;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [7:0]  notes_out;
    logic [1:0]  shift_out;
    logic        playing, done, src;
    logic [15:0] rom [64];
    int          checks = 0;
    int          errors = 0;

    song_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .key_notes(key_notes), .key_shift(key_shift), .rom_addr(rom_addr), .rom_data(rom_data),
        .notes_out(notes_out), .shift_out(shift_out), .playing(playing), .done(done), .src(src)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    // One entry per clock cycle after start: what the song alone should show.
    typedef struct packed {
        logic       playing;
        logic       done;
        logic       play;
        logic [5:0] addr;
        logic [7:0] notes;
        logic [1:0] shift;
    } exp_t;
    exp_t tl[$];

    function automatic exp_t mk(input logic pl, input logic dn, input logic py, input int ad,
                                input logic [7:0] nt, input logic [1:0] sh);
        exp_t r;
        r.playing = pl; r.done = dn; r.play = py; r.addr = 6'(ad); r.notes = nt; r.shift = sh;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'h8000;
    endtask

    task automatic build();
        int a = 0;
        int d;
        bit fin = 0;
        tl.delete();
        while (!fin) begin
            tl.push_back(mk(1, 0, 0, a, 8'h00, 2'b00));
            tl.push_back(mk(1, 0, 0, a, 8'h00, 2'b00));
            if (rom[a][15]) begin
                if (LOOP) a = 0;
                else begin
                    tl.push_back(mk(1, 1, 0, 0, 8'h00, 2'b00));
                    fin = 1;
                end
            end else begin
                d = rom[a][12:8] == 5'd0 ? 1 : int'(rom[a][12:8]);
                tl.push_back(mk(1, 0, 0, a, 8'h00, 2'b00));
                repeat (d * B) tl.push_back(mk(1, 0, 1, a, rom[a][7:0], rom[a][14:13]));
                repeat (G) tl.push_back(mk(1, 0, 1, a, 8'h00, rom[a][14:13]));
                if (a == 63 && !LOOP) begin
                    tl.push_back(mk(1, 1, 0, 0, 8'h00, 2'b00));
                    fin = 1;
                end
                a = (a + 1) % 64;
            end
            if (LOOP && tl.size() > 150) fin = 1;
        end
        if (!LOOP) repeat (2) tl.push_back(mk(0, 0, 0, 0, 8'h00, 2'b00));
    endtask

    task automatic run_song(input int key_at, input int key_len, input int pause_at, input int pause_len,
                            input int abort_at, input bit rnd, output int mask_cyc, output int done_cyc);
        exp_t       e;
        exp_t       prev;
        logic [7:0] ak, en;
        logic [1:0] aks, es;
        logic       ap, esrc;
        int         k = 0;
        build();
        mask_cyc = 0;
        done_cyc = 0;
        prev = mk(0, 0, 0, 0, 8'h00, 2'b00);
        @(negedge clk);
        key_notes = 8'h00; pause = 1'b0; start = 1'b1;
        ak = 8'h00; aks = key_shift; ap = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (tl.size() > 0 && k < 5000) begin
            if (!ap) prev = tl.pop_front();
            e = prev;
            en = ak != 8'h00 ? ak : (e.play && !ap) ? e.notes : 8'h00;
            es = ak != 8'h00 ? aks : (e.play && !ap) ? e.shift : 2'b00;
            esrc = ak == 8'h00 && e.play && !ap;
            chk("notes", notes_out, en);
            chk("shift", shift_out, es);
            chk("src", src, esrc);
            chk("playing", playing, e.playing);
            chk("done", done, e.done && !ap);
            chk("rom_addr", rom_addr, e.addr);
            if (src && notes_out != 8'h00) mask_cyc++;
            if (done) done_cyc++;
            k++;
            if (k == abort_at) begin
                key_notes = 8'h00; pause = 1'b0; stop = 1'b1; start = 1'b1;
                @(negedge clk);
                stop = 1'b0; start = 1'b0;
                chk("abort_playing", playing, 0);
                chk("abort_notes", notes_out, 0);
                chk("abort_addr", rom_addr, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_done", done, 0);
                end
                tl.delete();
                break;
            end
            if (rnd) begin
                if ($urandom_range(7) == 0) key_notes = $urandom_range(2) == 0 ? 8'($urandom) : 8'h00;
                key_shift = 2'($urandom);
                pause = prev.play && $urandom_range(3) == 0;
            end else begin
                key_notes = (k >= key_at && k < key_at + key_len) ? 8'h10 : 8'h00;
                pause = (k >= pause_at && k < pause_at + pause_len) && prev.play;
            end
            ak = key_notes; aks = key_shift; ap = pause;
            @(negedge clk);
        end
        if (k >= 5000) chk("run_bound", k, 0);
        key_notes = 8'h00; pause = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("end_playing", playing, 0);
        chk("end_notes", notes_out, 0);
        chk("end_addr", rom_addr, 0);
    endtask

    initial begin
        int mc, dc, n;
        clear_rom();
        #12;
        chk("rst_notes", notes_out, 0);
        chk("rst_shift", shift_out, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_src", src, 0);
        chk("rst_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single one-beat note then end.
        rom[0] = 16'h0101;
        run_song(-1, 0, -1, 0, -1, 0, mc, dc);
`ifndef SONG_SEQ_LOOP_EN
        chk("t1_mask_cycles", mc, 4);
        chk("t1_done_pulses", dc, 1);
`endif

        // Repeated two-beat note must retrigger through the gap.
        clear_rom();
        rom[0] = 16'h0204;
        rom[1] = 16'h0204;
        run_song(-1, 0, -1, 0, -1, 0, mc, dc);
`ifndef SONG_SEQ_LOOP_EN
        chk("t2_mask_cycles", mc, 16);
`endif

        // Keyboard override mid-note; song timing continues underneath.
        clear_rom();
        rom[0] = 16'h4401;
        rom[1] = 16'h0180;
        run_song(6, 3, -1, 0, -1, 0, mc, dc);

        // Pause mid-note for 10 cycles.
        clear_rom();
        rom[0] = 16'h0802;
        run_song(-1, 0, 10, 10, -1, 0, mc, dc);
`ifndef SONG_SEQ_LOOP_EN
        chk("pause_mask_cycles", mc, 32);
`endif

        // Stop and start together mid-song, then a fresh start from address 0.
        clear_rom();
        rom[0] = 16'h0204;
        rom[1] = 16'h0204;
        run_song(-1, 0, -1, 0, 8, 0, mc, dc);
        chk("abort_done_pulses", dc, 0);
        run_song(-1, 0, -1, 0, -1, 0, mc, dc);

        // Asynchronous reset in the gap.
        clear_rom();
        rom[0] = 16'h0101;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("gap_src", src, 1);
        chk("gap_playing", playing, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_playing", playing, 0);
        chk("arst_src", src, 0);
        chk("arst_notes", notes_out, 0);
        chk("arst_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", playing, 0);

        // Randomized songs with random keyboard activity and pauses.
        for (int it = 0; it < 8; it++) begin
            clear_rom();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                rom[i] = {1'b0, 2'($urandom), 5'($urandom_range(3)), 8'($urandom)};
            rom[n] = 16'h8000 | 16'($urandom_range(32767));
            run_song(-1, 0, -1, 0, -1, 1, mc, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
